// File: rtl/lb2ocu_sequencer.sv
// Window-address sequencer between the line/tile buffer and the output compute unit:
// walks kernel centre positions row-major, gated by how many input rows have landed.
package enums_conv_layer;
  typedef enum logic {SAME = 1'b0, VALID = 1'b1} padding_type;
endpackage

module lb2ocu_sequencer
  import enums_conv_layer::*;
#(
  parameter int K                 = 3,
  parameter int IMAGEWIDTH        = 32,
  parameter int IMAGEHEIGHT       = 32,
  parameter int COLADDRESSWIDTH   = $clog2(IMAGEWIDTH),
  parameter int ROWADDRESSWIDTH   = $clog2(IMAGEHEIGHT),
  parameter int TBROWADDRESSWIDTH = $clog2(K)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         new_layer_i,
  input  logic [TBROWADDRESSWIDTH-1:0] layer_stride_width_i,
  input  logic [TBROWADDRESSWIDTH-1:0] layer_stride_height_i,
  input  padding_type                  layer_padding_type_i,
  input  logic [COLADDRESSWIDTH:0]     layer_imagewidth_i,
  input  logic [ROWADDRESSWIDTH:0]     layer_imageheight_i,
  input  logic                         lb_row_valid_i,
  input  logic                         ready_i,
  output logic                         valid_o,
  output logic [COLADDRESSWIDTH-1:0]   read_col_o,
  output logic [TBROWADDRESSWIDTH-1:0] read_row_o,
  output logic [K-1:0]                 row_pad_mask_o,
  output logic [K-1:0]                 col_pad_mask_o,
  output logic                         last_o,
  output logic                         done_o,
  output logic                         busy_o
);

  localparam int CW = COLADDRESSWIDTH;
  localparam int RW = ROWADDRESSWIDTH;
  localparam int TW = TBROWADDRESSWIDTH;
  localparam int P  = (K - 1) / 2;
  localparam int AW = (CW > RW) ? CW : RW;
  localparam int CX = CW + 2;
  localparam int RX = RW + 2;

  typedef enum logic [1:0] {IDLE, WAIT_ROW, ISSUE, DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   sw_q, sh_q;
  padding_type     pad_q;
  logic [CW:0]     w_q;
  logic [RW:0]     h_q;
  logic [CW:0]     col_q;
  logic [RW:0]     row_q;
  logic [RW:0]     rows_wr_q;

  logic [CX-1:0]   col_nx;
  logic [RX-1:0]   row_nx;
  logic [RX-1:0]   row_need;
  logic [CW:0]     col_first;
  logic            col_past, row_past, rows_ok, row_in_body;
  logic [TW-1:0]   row_tb;

  // Saturating row-arrival counter: never counts past the image height.
  function automatic logic [RW:0] sat_inc(input logic [RW:0] v, input logic [RW:0] lim);
    return (v < lim) ? v + (RW+1)'(1) : v;
  endfunction

  // Bit j flags kernel tap (pos-P+j) as lying outside [0, dim-1].
  function automatic logic [K-1:0] pad_mask(input logic [AW:0] pos, input logic [AW:0] dim);
    logic signed [AW+2:0] idx;
    pad_mask = '0;
    for (int j = 0; j < K; j++) begin
      idx = $signed({2'b00, pos}) + (AW+3)'(j - P);
      pad_mask[j] = idx[AW+2] || (idx >= $signed({2'b00, dim}));
    end
  endfunction

  // Next-position arithmetic is done one bit wider still, so stepping past the edge never wraps.
  always_comb begin
    col_nx      = CX'(col_q) + CX'(sw_q);
    row_nx      = RX'(row_q) + RX'(sh_q);
    col_past    = (col_nx + ((pad_q == VALID) ? CX'(P + 1) : CX'(1))) > CX'(w_q);
    row_past    = (row_nx + ((pad_q == VALID) ? RX'(P + 1) : RX'(1))) > RX'(h_q);
    row_need    = ((RX'(row_q) + RX'(P + 1)) < RX'(h_q)) ? (RX'(row_q) + RX'(P + 1)) : RX'(h_q);
    rows_ok     = RX'(rows_wr_q) >= row_need;
    row_in_body = (RX'(row_q) + RX'(P + 1)) <= RX'(h_q);
    col_first   = (pad_q == VALID) ? (CW+1)'(P) : '0;
    row_tb      = (pad_q == VALID || row_in_body) ? TW'(P)
                                                  : TW'(RX'(row_q) + RX'(K) - RX'(h_q));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = IDLE;
      WAIT_ROW: if (rows_ok) state_d = ISSUE;
      ISSUE: begin
        if (ready_i) begin
          if (col_past && row_past) state_d = DONE;
          else if (col_past)        state_d = WAIT_ROW;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (new_layer_i) state_d = WAIT_ROW;
  end

  always_comb begin
    valid_o        = 1'b0;
    read_col_o     = '0;
    read_row_o     = '0;
    row_pad_mask_o = '0;
    col_pad_mask_o = '0;
    last_o         = 1'b0;
    done_o         = 1'b0;
    busy_o         = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        valid_o    = 1'b1;
        read_col_o = col_q[CW-1:0];
        read_row_o = row_tb;
        if (pad_q == SAME) begin
          row_pad_mask_o = pad_mask((AW+1)'(row_q), (AW+1)'(h_q));
          col_pad_mask_o = pad_mask((AW+1)'(col_q), (AW+1)'(w_q));
        end
        last_o = col_past && row_past;
      end
      DONE:    done_o = 1'b1;
      default: done_o = 1'b0;
    endcase
  end

  // Layer config, position counters and row counter; new_layer_i wins over everything but reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sw_q      <= '0;
      sh_q      <= '0;
      pad_q     <= SAME;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      rows_wr_q <= '0;
    end else if (new_layer_i) begin
      sw_q      <= (layer_stride_width_i == '0) ? TW'(1) : layer_stride_width_i;
      sh_q      <= (layer_stride_height_i == '0) ? TW'(1) : layer_stride_height_i;
      pad_q     <= layer_padding_type_i;
      w_q       <= layer_imagewidth_i;
      h_q       <= layer_imageheight_i;
      col_q     <= (layer_padding_type_i == VALID) ? (CW+1)'(P) : '0;
      row_q     <= (layer_padding_type_i == VALID) ? (RW+1)'(P) : '0;
      rows_wr_q <= '0;
    end else begin
      if (lb_row_valid_i) rows_wr_q <= sat_inc(rows_wr_q, h_q);
      if (state_q == ISSUE && ready_i) begin
        if (col_past) begin
          col_q <= col_first;
          if (!row_past) row_q <= row_nx[RW:0];
        end else begin
          col_q <= col_nx[CW:0];
        end
      end
    end
  end

endmodule
